// File: rtl/alu_regfile_datapath_pkg.sv
// Shared widths, opcode constants, ALU control encodings and PSR bit positions
// for the execute datapath (register file + ALU).
package alu_regfile_datapath_pkg;

    localparam int unsigned WIDTH = 16;
    localparam int unsigned NREGS = 16;
    localparam int unsigned AW    = $clog2(NREGS);
    localparam int unsigned OPW   = 4;
    localparam int unsigned PSRW  = 6;

    // PSR bit indices: {rsvd,N,Z,L,F,C}
    localparam int unsigned PSR_C    = 0;
    localparam int unsigned PSR_F    = 1;
    localparam int unsigned PSR_L    = 2;
    localparam int unsigned PSR_Z    = 3;
    localparam int unsigned PSR_N    = 4;
    localparam int unsigned PSR_RSVD = 5;

    // Opcode field [15:12] and extension [7:4] encodings
    localparam logic [OPW-1:0] OP_EXT  = 4'b0000;
    localparam logic [OPW-1:0] OP_AND  = 4'b0001;
    localparam logic [OPW-1:0] OP_OR   = 4'b0010;
    localparam logic [OPW-1:0] OP_XOR  = 4'b0011;
    localparam logic [OPW-1:0] OP_LSH  = 4'b0100;
    localparam logic [OPW-1:0] OP_ADD  = 4'b0101;
    localparam logic [OPW-1:0] OP_LSHI = 4'b1000;
    localparam logic [OPW-1:0] OP_SUB  = 4'b1001;
    localparam logic [OPW-1:0] OP_CMP  = 4'b1011;
    localparam logic [OPW-1:0] OP_MOV  = 4'b1101;

    typedef enum logic [3:0] {
        ALU_NOP = 4'd0,
        ALU_AND = 4'd1,
        ALU_OR  = 4'd2,
        ALU_XOR = 4'd3,
        ALU_ADD = 4'd4,
        ALU_SUB = 4'd5,
        ALU_CMP = 4'd6,
        ALU_MOV = 4'd7,
        ALU_LSH = 4'd8
    } alucont_t;

    // Register-format ops live in opext when the main opcode is zero;
    // the shift-immediate group reuses the LSH extension code.
    function automatic alucont_t decode_op(input logic [OPW-1:0] aluop,
                                           input logic [OPW-1:0] opext);
        logic [OPW-1:0] code;
        alucont_t       ctl;
        code = (aluop == OP_EXT) ? opext : aluop;
        ctl  = ALU_NOP;
        if (aluop == OP_LSHI && opext == OP_LSH) begin
            ctl = ALU_LSH;
        end else begin
            case (code)
                OP_AND:  ctl = ALU_AND;
                OP_OR:   ctl = ALU_OR;
                OP_XOR:  ctl = ALU_XOR;
                OP_ADD:  ctl = ALU_ADD;
                OP_SUB:  ctl = ALU_SUB;
                OP_CMP:  ctl = ALU_CMP;
                OP_MOV:  ctl = ALU_MOV;
                OP_LSH:  ctl = ALU_LSH;
                default: ctl = ALU_NOP;
            endcase
        end
        return ctl;
    endfunction

endpackage

// File: rtl/alu_regfile_datapath_if.sv
// Datapath bus: register-file write/read controls, opcode fields, and the
// operand/result/flag outputs returned to the CPU.
interface alu_regfile_datapath_if;
    import alu_regfile_datapath_pkg::*;

    logic              regwrite;
    logic [AW-1:0]     ra1;
    logic [AW-1:0]     ra2;
    logic [AW-1:0]     wa;
    logic [WIDTH-1:0]  wd;
    logic [OPW-1:0]    aluop;
    logic [OPW-1:0]    opext;
    logic [WIDTH-1:0]  rd1;
    logic [WIDTH-1:0]  rd2;
    logic [WIDTH-1:0]  result;
    logic [PSRW-1:0]   psr;

    // Controller side
    modport master (
        output regwrite, ra1, ra2, wa, wd, aluop, opext,
        input  rd1, rd2, result, psr
    );

    // Datapath side
    modport slave (
        input  regwrite, ra1, ra2, wa, wd, aluop, opext,
        output rd1, rd2, result, psr
    );

endinterface

// File: rtl/alu_regfile_datapath_regfile.sv
// 16x16 register file: two combinational read ports, one synchronous write
// port, synchronous reset clears every register (reset wins over write).
module regfile_16x16
    import alu_regfile_datapath_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             regwrite,
    input  logic [AW-1:0]    ra1,
    input  logic [AW-1:0]    ra2,
    input  logic [AW-1:0]    wa,
    input  logic [WIDTH-1:0] wd,
    output logic [WIDTH-1:0] rd1,
    output logic [WIDTH-1:0] rd2
);

    logic [WIDTH-1:0] regs [NREGS];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(NREGS); i++) begin
                regs[i] <= '0;
            end
        end else if (regwrite) begin
            regs[wa] <= wd;
        end
    end

    // Reads see the pre-edge contents during a same-cycle write
    assign rd1 = regs[ra1];
    assign rd2 = regs[ra2];

endmodule

// File: rtl/alu_regfile_datapath.sv
// Execute datapath core: register file, opcode decode and a zero-latency
// 16-bit ALU producing the result and PSR flags.
module alu_regfile_datapath
    import alu_regfile_datapath_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    alu_regfile_datapath_if.slave bus
);

    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    alucont_t         alucont;

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic [AW-1:0]    rshamt;
    logic [WIDTH-1:0] res_c;
    logic [PSRW-1:0]  psr_c;

    regfile_16x16 u_regfile (
        .clk      (clk),
        .reset    (reset),
        .regwrite (bus.regwrite),
        .ra1      (bus.ra1),
        .ra2      (bus.ra2),
        .wa       (bus.wa),
        .wd       (bus.wd),
        .rd1      (a),
        .rd2      (b)
    );

    assign alucont = decode_op(bus.aluop, bus.opext);

    // Shared adders; diff[WIDTH] is the unsigned borrow of B-A
    assign sum    = {1'b0, b} + {1'b0, a};
    assign diff   = {1'b0, b} - {1'b0, a};
    assign rshamt = AW'(4'd0 - a[AW-1:0]);

    always_comb begin
        res_c = b;
        psr_c = '0;
        case (alucont)
            ALU_AND: res_c = b & a;
            ALU_OR:  res_c = b | a;
            ALU_XOR: res_c = b ^ a;
            ALU_MOV: res_c = a;
            ALU_LSH: res_c = a[WIDTH-1] ? (b >> rshamt) : (b << a[AW-1:0]);
            ALU_ADD: begin
                res_c        = sum[WIDTH-1:0];
                psr_c[PSR_C] = sum[WIDTH];
                psr_c[PSR_F] = (a[WIDTH-1] == b[WIDTH-1]) &&
                               (sum[WIDTH-1] != a[WIDTH-1]);
            end
            ALU_SUB, ALU_CMP: begin
                res_c        = diff[WIDTH-1:0];
                psr_c[PSR_C] = diff[WIDTH];
                psr_c[PSR_F] = (a[WIDTH-1] != b[WIDTH-1]) &&
                               (diff[WIDTH-1] != b[WIDTH-1]);
                psr_c[PSR_L] = (b < a);
                psr_c[PSR_N] = ($signed(b) < $signed(a));
                psr_c[PSR_Z] = (a == b);
            end
            default: res_c = b;
        endcase
    end

    assign bus.rd1    = a;
    assign bus.rd2    = b;
    assign bus.result = res_c;
    assign bus.psr    = psr_c;

endmodule

// File: tb/tb_alu_regfile_datapath.sv
// Directed scoreboard bench for alu_regfile_datapath: stimulus queues the
// expected response, a negedge monitor pops and compares.
module tb_alu_regfile_datapath;

    logic clk;
    logic reset;
    logic stim_done;
    int   checks;
    int   failures;

    alu_regfile_datapath_if bus ();

    alu_regfile_datapath dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // mask bits: [0] rd1, [1] rd2, [2] result, [3] psr
    typedef struct {
        string       name;
        logic [3:0]  mask;
        logic [15:0] rd1;
        logic [15:0] rd2;
        logic [15:0] result;
        logic [5:0]  psr;
    } exp_t;

    exp_t sb [$];

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input string n, input logic [3:0] m, input logic [15:0] e1,
                        input logic [15:0] e2, input logic [15:0] er, input logic [5:0] ep);
        exp_t e;
        e.name = n; e.mask = m; e.rd1 = e1; e.rd2 = e2; e.result = er; e.psr = ep;
        sb.push_back(e);
    endtask

    task automatic wr(input logic [3:0] a, input logic [15:0] d);
        bus.regwrite = 1'b1;
        bus.wa       = a;
        bus.wd       = d;
        cyc();
        bus.regwrite = 1'b0;
    endtask

    task automatic alu(input string n, input logic [3:0] r1, input logic [3:0] r2,
                       input logic [3:0] op, input logic [3:0] ext,
                       input logic [15:0] eres, input logic [5:0] epsr);
        bus.ra1   = r1;
        bus.ra2   = r2;
        bus.aluop = op;
        bus.opext = ext;
        push(n, 4'b1100, 16'h0, 16'h0, eres, epsr);
        cyc();
    endtask

    task automatic cmp(input string n, input string f, input logic [15:0] got,
                       input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s.%s got=%h exp=%h", n, f, got, exp);
        end
    endtask

    // Monitor: compares every queued expectation against the live outputs
    initial begin
        int   ncyc;
        exp_t e;
        ncyc     = 0;
        checks   = 0;
        failures = 0;
        while (!(stim_done && sb.size() == 0) && ncyc < 5000) begin
            @(negedge clk);
            ncyc++;
            while (sb.size() > 0) begin
                e = sb.pop_front();
                if (e.mask[0]) cmp(e.name, "rd1", bus.rd1, e.rd1);
                if (e.mask[1]) cmp(e.name, "rd2", bus.rd2, e.rd2);
                if (e.mask[2]) cmp(e.name, "result", bus.result, e.result);
                if (e.mask[3]) cmp(e.name, "psr", 16'(bus.psr), 16'(e.psr));
            end
        end
        if (!(stim_done && sb.size() == 0)) begin
            failures++;
            $display("FAIL timeout pending=%0d stim_done=%0d", sb.size(), stim_done);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Stimulus
    initial begin
        stim_done    = 1'b0;
        reset        = 1'b1;
        bus.regwrite = 1'b0;
        bus.ra1      = '0;
        bus.ra2      = '0;
        bus.wa       = '0;
        bus.wd       = '0;
        bus.aluop    = '0;
        bus.opext    = '0;
        cyc();
        reset = 1'b0;

        // Every register reads zero after reset
        for (int i = 0; i < 16; i += 2) begin
            bus.ra1 = 4'(i);
            bus.ra2 = 4'(i + 1);
            push($sformatf("reset_r%0d", i), 4'b0011, 16'h0000, 16'h0000, 16'h0, 6'h0);
            cyc();
        end

        wr(4'd3, 16'h000A);
        wr(4'd2, 16'h000A);
        bus.ra1 = 4'd3;
        bus.ra2 = 4'd2;
        push("read_r3_r2", 4'b0011, 16'h000A, 16'h000A, 16'h0, 6'h0);
        cyc();

        // Logic ops, MOV and NOP pass-through
        wr(4'd1, 16'h07FF);
        wr(4'd2, 16'h03FF);
        alu("and", 4'd1, 4'd2, 4'b0001, 4'b0000, 16'h03FF, 6'h00);
        alu("or",  4'd1, 4'd2, 4'b0010, 4'b0000, 16'h07FF, 6'h00);
        alu("xor", 4'd1, 4'd2, 4'b0011, 4'b0000, 16'h0400, 6'h00);
        alu("mov", 4'd1, 4'd2, 4'b1101, 4'b0000, 16'h07FF, 6'h00);
        alu("nop", 4'd1, 4'd2, 4'b0000, 4'b0000, 16'h03FF, 6'h00);
        alu("ext_and", 4'd1, 4'd2, 4'b0000, 4'b0001, 16'h03FF, 6'h00);
        // 0x03FF-0x07FF = 0xFC00: borrow, L, N set
        alu("sub", 4'd1, 4'd2, 4'b1001, 4'b0000, 16'hFC00, 6'h15);

        // ADD carry / overflow
        wr(4'd1, 16'hFFFF);
        wr(4'd2, 16'hFFFF);
        alu("add_carry", 4'd1, 4'd2, 4'b0101, 4'b0000, 16'hFFFE, 6'h01);
        wr(4'd1, 16'h0001);
        wr(4'd2, 16'h0001);
        alu("add_small", 4'd1, 4'd2, 4'b0101, 4'b0000, 16'h0002, 6'h00);
        wr(4'd1, 16'h7FFF);
        wr(4'd2, 16'h0004);
        alu("add_ovf", 4'd1, 4'd2, 4'b0101, 4'b0000, 16'h8003, 6'h02);

        // CMP via extension: unsigned-less, signed-less, equal
        wr(4'd1, 16'hFFFF);
        wr(4'd2, 16'h0001);
        alu("cmp_lo",  4'd1, 4'd2, 4'b0000, 4'b1011, 16'h0002, 6'h05);
        alu("cmp_neg", 4'd2, 4'd1, 4'b0000, 4'b1011, 16'hFFFE, 6'h10);
        alu("cmp_eq",  4'd1, 4'd1, 4'b0000, 4'b1011, 16'h0000, 6'h08);
        wr(4'd1, 16'h8000);
        alu("cmp_ovf", 4'd1, 4'd2, 4'b1011, 4'b0000, 16'h8001, 6'h07);

        // LSH: positive amount shifts left, negative shifts right logically
        wr(4'd4, 16'h0003);
        wr(4'd5, 16'h0011);
        wr(4'd6, 16'hFFFE);
        wr(4'd7, 16'h8000);
        alu("lsh_left",  4'd4, 4'd5, 4'b0100, 4'b0000, 16'h0088, 6'h00);
        alu("lsh_right", 4'd6, 4'd7, 4'b0100, 4'b0000, 16'h2000, 6'h00);
        alu("lshi",      4'd6, 4'd7, 4'b1000, 4'b0100, 16'h2000, 6'h00);
        alu("undef_op",  4'd6, 4'd7, 4'b1111, 4'b0000, 16'h8000, 6'h00);

        // Read-during-write returns old contents until the edge
        bus.aluop    = 4'b0000;
        bus.opext    = 4'b0000;
        bus.ra1      = 4'd8;
        bus.ra2      = 4'd0;
        bus.regwrite = 1'b1;
        bus.wa       = 4'd8;
        bus.wd       = 16'h1234;
        push("rdw_old", 4'b0001, 16'h0000, 16'h0, 16'h0, 6'h0);
        cyc();
        bus.regwrite = 1'b0;
        push("rdw_new", 4'b0001, 16'h1234, 16'h0, 16'h0, 6'h0);
        cyc();

        // Reset wins over a same-edge write and clears everything
        reset        = 1'b1;
        bus.regwrite = 1'b1;
        bus.wa       = 4'd8;
        bus.wd       = 16'hBEEF;
        cyc();
        reset        = 1'b0;
        bus.regwrite = 1'b0;
        bus.ra1      = 4'd8;
        bus.ra2      = 4'd7;
        push("reset_beats_write", 4'b0011, 16'h0000, 16'h0000, 16'h0, 6'h0);
        cyc();

        stim_done = 1'b1;
    end

endmodule
